// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for an external shifter: one transaction
// in flight, operands latched onto the shifter port, result held until taken.
module shifter_arbiter #(
  parameter int SHIFT_LATENCY = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [1:0]  Req_Valid,
  output logic [1:0]  Req_Ready,
  input  logic [1:0]  Req_Direction,
  input  logic [5:0]  Req_Shift_Amount,
  input  logic [15:0] Req_Data_In,
  output logic [1:0]  Rsp_Valid,
  input  logic [1:0]  Rsp_Ready,
  output logic [7:0]  Rsp_Data,
  output logic        Sh_Direction,
  output logic [2:0]  Sh_Shift_Amount,
  output logic [7:0]  Sh_Data_In,
  input  logic [7:0]  Sh_Data_Out,
  output logic        Busy
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHIFT_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             dir_q, dir_d;
  logic [2:0]       amt_q, amt_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       result_q, result_d;

  logic             grant_id;
  logic [1:0]       grant_onehot;
  logic             sel_dir;
  logic [2:0]       sel_amt;
  logic [7:0]       sel_data;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    case (Req_Valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      default: grant_id = ptr_q;
    endcase
    grant_onehot = grant_id ? 2'b10 : 2'b01;
    sel_dir      = Req_Direction[grant_id];
    sel_amt      = grant_id ? Req_Shift_Amount[5:3] : Req_Shift_Amount[2:0];
    sel_data     = grant_id ? Req_Data_In[15:8]     : Req_Data_In[7:0];
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dir_d     = dir_q;
    amt_d     = amt_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    Req_Ready = 2'b00;
    Rsp_Valid = 2'b00;

    case (state_q)
      ST_IDLE: begin
        Req_Ready = grant_onehot & Req_Valid;
        if (Req_Valid[grant_id]) begin
          id_d    = grant_id;
          dir_d   = sel_dir;
          amt_d   = sel_amt;
          data_d  = sel_data;
          cnt_d   = CNT_LOAD;
          ptr_d   = ~grant_id;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          result_d = Sh_Data_Out;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        Rsp_Valid = id_q ? 2'b10 : 2'b01;
        if (Rsp_Ready[id_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is combinational from Req_Valid, so it must be masked while reset
    // holds the flops, not just after the first edge.
    if (!Reset_n) begin
      Req_Ready = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      dir_q    <= 1'b0;
      amt_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      dir_q    <= dir_d;
      amt_q    <= amt_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign Sh_Direction    = dir_q;
  assign Sh_Shift_Amount = amt_q;
  assign Sh_Data_In      = data_q;
  assign Rsp_Data        = result_q;
  assign Busy            = (state_q != ST_IDLE);

endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 Parameter SHIFT_LATENCY, default 1: clock edges from the shifter sampling its inputs to a valid Data_Out; legal range 1-4.
REQ-002 Clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 Req_Valid  in  2  per-requester request valid; bit 0 = requester 0, bit 1 = requester 1.
REQ-005 Req_Ready  out  2  per-requester request accept.
REQ-006 Req_Direction  in  2  per-requester direction; 0 = left, 1 = right.
REQ-007 Req_Shift_Amount  in  6  {req1[2:0], req0[2:0]} shift amounts.
REQ-008 Req_Data_In  in  16  {req1[7:0], req0[7:0]} operands.
REQ-009 Rsp_Valid  out  2  per-requester result valid.
REQ-010 Rsp_Ready  in  2  per-requester result accept.
REQ-011 Rsp_Data  out  8  result; valid only for the requester whose Rsp_Valid bit is high.
REQ-012 Sh_Direction  out  1  to shifter Direction.
REQ-013 Sh_Shift_Amount  out  3  to shifter Shift_Amount.
REQ-014 Sh_Data_In  out  8  to shifter Data_In.
REQ-015 Sh_Data_Out  in  8  from shifter Data_Out.
REQ-016 Busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; exactly one transaction is in flight at a time.
REQ-018 In IDLE, Req_Ready[i] is high only for the granted requester i and only when Req_Valid[i] is high. In WAIT and RESP, Req_Ready is 2'b00.
REQ-019 Grant with one valid requester: that requester.
REQ-020 Grant with both valid: the requester selected by the round-robin pointer. The pointer points to requester 0 after reset and moves to the non-granted requester on every accept.
REQ-021 Accept = Req_Valid[i] & Req_Ready[i] at a clock edge. That edge registers direction, amount, data and requester id, drives the registered values onto Sh_*, loads the wait counter with SHIFT_LATENCY+1, and moves the FSM IDLE -> WAIT.
REQ-022 Sh_* outputs hold the latched values unchanged from the accept edge until the next accept.
REQ-023 In WAIT, the counter decrements on each edge. On the edge where the counter equals 1, Sh_Data_Out is registered into the result register and the FSM moves WAIT -> RESP.
REQ-024 With SHIFT_LATENCY=1: accept at edge t, result captured at edge t+2, Rsp_Valid high after edge t+2.
REQ-025 In RESP, Rsp_Valid[id] is high, the other bit is low, and Rsp_Data holds the captured result stable until Rsp_Valid[id] & Rsp_Ready[id] at an edge, which moves RESP -> IDLE.
REQ-026 Rsp_Ready held low keeps the FSM in RESP indefinitely; no new request is accepted.
REQ-027 A requester dropping Req_Valid before it is accepted is legal; no transaction starts for it.
REQ-028 Rsp_Ready of the non-owning requester is ignored.
REQ-029 The block passes all Shift_Amount values 0-7 through unmodified; no shift arithmetic is performed inside this block.
REQ-030 A new request can be accepted at the earliest in the cycle after a response handshake, because the FSM must return to IDLE first.

Reset
REQ-031 Reset_n low asynchronously forces: state IDLE, Req_Ready 0, Rsp_Valid 0, Rsp_Data 0, Sh_Direction 0, Sh_Shift_Amount 0, Sh_Data_In 0, Busy 0, counter 0, pointer to requester 0.
REQ-032 Reset asserted mid-transaction (WAIT or RESP) discards the in-flight transaction; no response is issued for it after reset releases.

Verification
REQ-033 Req0: left, amount 1, data 00001111 -> Sh_* = 0/1/00001111 after accept; with SHIFT_LATENCY=1, Rsp_Valid=01 two edges after accept; Rsp_Data = 00011110.
REQ-034 Req1: right, amount 3, data 00001111 -> Rsp_Valid=10, Rsp_Data = 00000001; Req_Ready stays 00 throughout WAIT and RESP.
REQ-035 Both requesters valid from reset, Rsp_Ready=11 -> grants alternate 0,1,0,1 over four transactions.
REQ-036 Req0: left, amount 4, data 11110000, Rsp_Ready low for 5 cycles -> Rsp_Valid=01 and Rsp_Data=00000000 held all 5 cycles; Busy=1; a Req1 request waiting during this time is not accepted.
REQ-037 Reset_n pulsed low while in WAIT -> all outputs go to their reset values immediately, without waiting for a clock edge; no Rsp_Valid after release; the next request is granted to requester 0 when both are valid.
